// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared constants and packed types for the CDB / register-file write-back arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_wb_arbiter_pkg;

    localparam int FU_NUM    = 4;
    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 5;
    localparam int DATA_W    = 64;
    localparam int FU_IDX_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    // Destination index meaning "no architectural destination"; broadcast but never written.
    localparam logic [PRF_IDX_W-1:0] ZERO_PREG = '0;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] preg;
        logic [ROB_IDX_W-1:0] rob;
        logic [DATA_W-1:0]    data;
    } fu_result_t;

    typedef struct packed {
        logic                 valid;
        logic [PRF_IDX_W-1:0] preg;
        logic [ROB_IDX_W-1:0] rob;
    } cdb_pkt_t;

    // Round-robin successor, wrapping at FU_NUM (FU_NUM need not be a power of two).
    function automatic logic [FU_IDX_W-1:0] rr_next(input logic [FU_IDX_W-1:0] idx);
        return (idx == FU_IDX_W'(FU_NUM - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer updates at the edge after a grant.
// Backpressure: none; caller masks req to suppress grants (pointer then holds).
// Ports: clk/rst (sync, active-high); req[FU_NUM] in; gnt[FU_NUM] one-hot, gnt_idx, gnt_vld out.
module cdb_wb_arbiter_rr_arbiter
    import cdb_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [FU_NUM-1:0]   req,
    output logic [FU_NUM-1:0]   gnt,
    output logic [FU_IDX_W-1:0] gnt_idx,
    output logic                gnt_vld
);

    logic [FU_IDX_W-1:0] rr_ptr_q;
    logic [FU_IDX_W:0]   pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            // Walk from the pointer, wrapping with a subtract rather than a modulo.
            pos = {1'b0, rr_ptr_q} + (FU_IDX_W+1)'(k);
            if (pos >= (FU_IDX_W+1)'(FU_NUM)) begin
                pos = pos - (FU_IDX_W+1)'(FU_NUM);
            end
            if (!gnt_vld && req[pos[FU_IDX_W-1:0]]) begin
                gnt_vld                 = 1'b1;
                gnt_idx                 = pos[FU_IDX_W-1:0];
                gnt[pos[FU_IDX_W-1:0]]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (gnt_vld) begin
            rr_ptr_q <= rr_next(gnt_idx);
        end
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Collects FU results into one-entry buffers and retires one per cycle round-robin to PRF write + CDB.
// Latency: 2 cycles accept-to-output; 1 cycle when CDB_WB_BYPASS_EN is defined and the arrival wins.
// Backpressure: fu_ready_o[i] = buffer empty or being granted this cycle; flush drops everything.
// Ports: clk, rst (sync, active-high), flush_i; per-FU valid/preg/rob/data in, fu_ready_o out;
//        prf_wr_en/idx/data and cdb_valid/preg/rob outputs, all registered.
// Optional macro: CDB_WB_BYPASS_EN (an arriving result competes in the same cycle as buffers).
module cdb_wb_arbiter
    import cdb_wb_arbiter_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic [FU_NUM-1:0]                fu_valid_i,
    input  logic [FU_NUM-1:0][PRF_IDX_W-1:0] fu_preg_idx_i,
    input  logic [FU_NUM-1:0][ROB_IDX_W-1:0] fu_rob_idx_i,
    input  logic [FU_NUM-1:0][DATA_W-1:0]    fu_data_i,
    output logic [FU_NUM-1:0]                fu_ready_o,
    output logic                             prf_wr_en_o,
    output logic [PRF_IDX_W-1:0]             prf_wr_idx_o,
    output logic [DATA_W-1:0]                prf_wr_data_o,
    output logic                             cdb_valid_o,
    output logic [PRF_IDX_W-1:0]             cdb_preg_idx_o,
    output logic [ROB_IDX_W-1:0]             cdb_rob_idx_o
);

    fu_result_t [FU_NUM-1:0] buf_q;
    logic       [FU_NUM-1:0] buf_vld_q;

    fu_result_t [FU_NUM-1:0] in_res;
    fu_result_t [FU_NUM-1:0] cand;
    fu_result_t              sel;
    logic       [FU_NUM-1:0] req;
    logic       [FU_NUM-1:0] gnt;
    logic       [FU_IDX_W-1:0] gnt_idx;
    logic                    gnt_vld;
    logic       [FU_NUM-1:0] xfer;
    logic       [FU_NUM-1:0] byp_win;
    logic       [FU_NUM-1:0] load;

    cdb_pkt_t                cdb_q;
    logic                    wr_en_q;
    logic       [DATA_W-1:0] wr_data_q;

    always_comb begin
        in_res = '0;
        cand   = '0;
        req    = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            in_res[i] = '{preg: fu_preg_idx_i[i], rob: fu_rob_idx_i[i], data: fu_data_i[i]};
`ifdef CDB_WB_BYPASS_EN
            // A buffered entry always represents its FU first so per-FU order is preserved;
            // an empty buffer lets the new arrival compete directly.
            req[i]  = buf_vld_q[i] | fu_valid_i[i];
            cand[i] = buf_vld_q[i] ? buf_q[i] : in_res[i];
`else
            req[i]  = buf_vld_q[i];
            cand[i] = buf_q[i];
`endif
        end
        if (flush_i) begin
            req = '0;
        end
    end

    cdb_wb_arbiter_rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign sel        = cand[gnt_idx];
    assign fu_ready_o = ~buf_vld_q | gnt;
    assign xfer       = fu_valid_i & fu_ready_o;

`ifdef CDB_WB_BYPASS_EN
    // Granted FU with an empty buffer means the arrival itself went out; do not also buffer it.
    assign byp_win = gnt & ~buf_vld_q;
`else
    assign byp_win = '0;
`endif

    assign load = xfer & ~byp_win & {FU_NUM{~flush_i}};

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            buf_vld_q <= '0;
        end else begin
            // Grant+load reloads, grant alone empties, load alone fills.
            buf_vld_q <= load | (buf_vld_q & ~gnt);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_NUM; i++) begin
            if (load[i]) begin
                buf_q[i] <= in_res[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            cdb_q.valid <= gnt_vld;
            cdb_q.preg  <= gnt_vld ? sel.preg : '0;
            cdb_q.rob   <= gnt_vld ? sel.rob  : '0;
            wr_data_q   <= gnt_vld ? sel.data : '0;
            wr_en_q     <= gnt_vld && (sel.preg != ZERO_PREG);
        end
    end

    assign cdb_valid_o    = cdb_q.valid;
    assign cdb_preg_idx_o = cdb_q.preg;
    assign cdb_rob_idx_o  = cdb_q.rob;
    assign prf_wr_en_o    = wr_en_q;
    assign prf_wr_idx_o   = cdb_q.preg;
    assign prf_wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Self-checking bench for cdb_wb_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: model predicts each registered output one cycle after the decision cycle.
// Backpressure: model predicts fu_ready_o every non-reset cycle.
module tb_cdb_wb_arbiter;
    import cdb_wb_arbiter_pkg::*;

`ifdef CDB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             rst;
    logic                             flush;
    logic [FU_NUM-1:0]                fu_valid;
    logic [FU_NUM-1:0][PRF_IDX_W-1:0] fu_preg;
    logic [FU_NUM-1:0][ROB_IDX_W-1:0] fu_rob;
    logic [FU_NUM-1:0][DATA_W-1:0]    fu_data;
    logic [FU_NUM-1:0]                fu_ready;
    logic                             prf_wr_en;
    logic [PRF_IDX_W-1:0]             prf_wr_idx;
    logic [DATA_W-1:0]                prf_wr_data;
    logic                             cdb_valid;
    logic [PRF_IDX_W-1:0]             cdb_preg;
    logic [ROB_IDX_W-1:0]             cdb_rob;

    cdb_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .fu_valid_i     (fu_valid),
        .fu_preg_idx_i  (fu_preg),
        .fu_rob_idx_i   (fu_rob),
        .fu_data_i      (fu_data),
        .fu_ready_o     (fu_ready),
        .prf_wr_en_o    (prf_wr_en),
        .prf_wr_idx_o   (prf_wr_idx),
        .prf_wr_data_o  (prf_wr_data),
        .cdb_valid_o    (cdb_valid),
        .cdb_preg_idx_o (cdb_preg),
        .cdb_rob_idx_o  (cdb_rob)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each FU holds at most one pending result; a pointer names who goes first.
    bit                   m_vld  [FU_NUM];
    logic [PRF_IDX_W-1:0] m_preg [FU_NUM];
    logic [ROB_IDX_W-1:0] m_rob  [FU_NUM];
    logic [DATA_W-1:0]    m_data [FU_NUM];
    int                   m_ptr;

    bit                   e_vld;
    bit                   e_wr;
    logic [PRF_IDX_W-1:0] e_idx;
    logic [ROB_IDX_W-1:0] e_rob;
    logic [DATA_W-1:0]    e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Caller sets inputs just after an edge; this predicts and checks one full cycle.
    task automatic cycle();
        int                win;
        int                f;
        logic [FU_NUM-1:0] rdy;
        logic [FU_NUM-1:0] xf;
        #1;
        if (rst) begin
            for (int i = 0; i < FU_NUM; i++) m_vld[i] = 1'b0;
            m_ptr  = 0;
            e_vld  = 1'b0;
            e_wr   = 1'b0;
            e_idx  = '0;
            e_rob  = '0;
            e_data = '0;
        end else begin
            win = -1;
            if (!flush) begin
                for (int k = 0; k < FU_NUM; k++) begin
                    f = (m_ptr + k) % FU_NUM;
                    if (win < 0 && (m_vld[f] || (BYP && fu_valid[f]))) win = f;
                end
            end
            for (int i = 0; i < FU_NUM; i++) rdy[i] = !m_vld[i] || (win == i);
            chk("ready", 64'(fu_ready), 64'(rdy));
            xf = fu_valid & rdy;
            if (win >= 0) begin
                e_vld = 1'b1;
                if (m_vld[win]) begin
                    e_idx = m_preg[win]; e_rob = m_rob[win]; e_data = m_data[win];
                end else begin
                    e_idx = fu_preg[win]; e_rob = fu_rob[win]; e_data = fu_data[win];
                end
                e_wr  = (e_idx != ZERO_PREG);
                m_ptr = (win + 1) % FU_NUM;
            end else begin
                e_vld = 1'b0; e_wr = 1'b0; e_idx = '0; e_rob = '0; e_data = '0;
            end
            for (int i = 0; i < FU_NUM; i++) begin
                if (flush) begin
                    m_vld[i] = 1'b0;
                end else if (xf[i] && !(win == i && !m_vld[i])) begin
                    m_vld[i]  = 1'b1;
                    m_preg[i] = fu_preg[i];
                    m_rob[i]  = fu_rob[i];
                    m_data[i] = fu_data[i];
                end else if (win == i) begin
                    m_vld[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(e_vld));
        chk("prf_wr_en", 64'(prf_wr_en), 64'(e_wr));
        chk("prf_wr_idx", 64'(prf_wr_idx), 64'(e_idx));
        chk("cdb_preg", 64'(cdb_preg), 64'(e_idx));
        chk("cdb_rob", 64'(cdb_rob), 64'(e_rob));
        chk("prf_wr_data", prf_wr_data, e_data);
    endtask

    task automatic send(input int fu, input int preg, input int rob, input logic [63:0] data);
        fu_valid[fu] = 1'b1;
        fu_preg[fu]  = PRF_IDX_W'(preg);
        fu_rob[fu]   = ROB_IDX_W'(rob);
        fu_data[fu]  = data;
    endtask

    int exp_fu;
    int n_gnt;

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_preg  = '0;
        fu_rob   = '0;
        fu_data  = '0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_ready", 64'(fu_ready), 64'hF);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_wr_en", 64'(prf_wr_en), 64'h0);

        // Single FU1 result
        send(1, 5, 3, 64'hDEAD);
        cycle();
        fu_valid = '0;
        repeat (LAT - 1) cycle();
        chk("single_wr_en", 64'(prf_wr_en), 64'h1);
        chk("single_idx", 64'(prf_wr_idx), 64'h5);
        chk("single_data", prf_wr_data, 64'hDEAD);
        chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("single_rob", 64'(cdb_rob), 64'h3);
        cycle();
        chk("single_after_valid", 64'(cdb_valid), 64'h0);
        chk("single_after_wr_en", 64'(prf_wr_en), 64'h0);

        // All FUs saturated from reset: grants must rotate 0,1,2,3,...
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        exp_fu = 0;
        n_gnt  = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < FU_NUM; i++) send(i, 8 + i, i, {$urandom, $urandom});
            cycle();
            if (cdb_valid) begin
                chk("rr_order", 64'(cdb_rob), 64'(exp_fu));
                exp_fu = (exp_fu + 1) % FU_NUM;
                n_gnt++;
            end
        end
        chk("rr_grant_count", 64'(n_gnt >= 14), 64'h1);
        fu_valid = '0;
        repeat (6) cycle();

        // ZERO_PREG result: broadcast, no register write
        send(2, 0, 7, 64'h1234);
        cycle();
        fu_valid = '0;
        repeat (LAT - 1) cycle();
        chk("zero_cdb_valid", 64'(cdb_valid), 64'h1);
        chk("zero_rob", 64'(cdb_rob), 64'h7);
        chk("zero_wr_en", 64'(prf_wr_en), 64'h0);
        repeat (2) cycle();

        // Flush with FU0/FU3 buffered and FU1 arriving
        send(0, 11, 1, 64'hA0);
        send(3, 12, 2, 64'hA3);
        cycle();
        fu_valid = '0;
        flush    = 1'b1;
        send(1, 13, 3, 64'hA1);
        cycle();
        flush    = 1'b0;
        fu_valid = '0;
        chk("flush_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("flush_wr_en", 64'(prf_wr_en), 64'h0);
        chk("flush_ready", 64'(fu_ready), 64'hF);
        for (int i = 0; i < FU_NUM; i++) send(i, 20 + i, 10 + i, 64'(i));
        cycle();
        fu_valid = '0;
        repeat (6) cycle();

        // Reset with three buffers loaded, then a lone FU2 result
        send(0, 1, 1, 64'h10);
        send(1, 2, 2, 64'h11);
        send(2, 3, 3, 64'h12);
        cycle();
        fu_valid = '0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(cdb_valid), 64'h0);
        chk("rst_mid_ready", 64'(fu_ready), 64'hF);
        send(2, 12, 4, 64'hBEEF);
        cycle();
        fu_valid = '0;
        repeat (LAT - 1) cycle();
        chk("rst_lone_valid", 64'(cdb_valid), 64'h1);
        chk("rst_lone_idx", 64'(prf_wr_idx), 64'd12);
        chk("rst_lone_data", prf_wr_data, 64'hBEEF);
        cycle();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < FU_NUM; i++) begin
                fu_valid[i] = ($urandom_range(0, 99) < 55);
                fu_preg[i]  = ($urandom_range(0, 7) == 0) ? ZERO_PREG : PRF_IDX_W'($urandom);
                fu_rob[i]   = ROB_IDX_W'($urandom);
                fu_data[i]  = {$urandom, $urandom};
            end
            cycle();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
